// File: rtl/aer_out_receiver.sv
`default_nettype none
// ============================================================================
// aer_out_receiver: four-phase AER output receiver with event FIFO and
// per-sample spike counter.  Rev 1.0
// ============================================================================
module aer_out_receiver #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [ADDR_W-1:0]             AEROUT_ADDR,
  input  logic                          AEROUT_REQ,
  output logic                          AEROUT_ACK,
  input  logic                          SAMPLE_DONE,
  output logic                          EVT_VALID,
  output logic [ADDR_W-1:0]             EVT_ADDR,
  input  logic                          EVT_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic [CNT_W-1:0]              SPIKE_COUNT,
  output logic [CNT_W-1:0]              SAMPLE_SPIKES
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  SPIKE_MAX = '1;
  localparam logic [0:0]        IDLE      = 1'b0;
  localparam logic [0:0]        ACK       = 1'b1;

  logic              req_meta_q, req_s_q;
  logic [0:0]        state_q, state_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic [CNT_W-1:0]  spike_q, spike_d;
  logic [CNT_W-1:0]  sample_q, sample_d;
  logic [CNT_W-1:0]  spike_inc;
  logic              push, pop;

  // Full check looks only at pre-edge occupancy, so a same-edge pop never frees a slot.
  always_comb begin
    push = (state_q == IDLE) && req_s_q && (count_q != DEPTH_C);
    pop  = EVT_READY && valid_q;
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    case (state_q)
      IDLE: begin
        if (push) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end
      end
      default: begin
        if (!req_s_q) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = AEROUT_ADDR;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    valid_d = (count_d != '0);
    // The new head may be the word written on this very edge, not yet in mem_q.
    head_d = head_q;
    if (count_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        head_d = AEROUT_ADDR;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_comb begin
    spike_inc = (spike_q == SPIKE_MAX) ? spike_q : spike_q + 1'b1;
    spike_d   = spike_q;
    sample_d  = sample_q;
    if (SAMPLE_DONE) begin
      sample_d = push ? spike_inc : spike_q;
      spike_d  = push ? CNT_W'(1) : '0;
    end else if (push) begin
      spike_d = spike_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      spike_q    <= '0;
      sample_q   <= '0;
    end else begin
      req_meta_q <= AEROUT_REQ;
      req_s_q    <= req_meta_q;
      state_q    <= state_d;
      ack_q      <= ack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      spike_q    <= spike_d;
      sample_q   <= sample_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign AEROUT_ACK    = ack_q;
  assign EVT_VALID     = valid_q;
  assign EVT_ADDR      = head_q;
  assign FIFO_COUNT    = count_q;
  assign SPIKE_COUNT   = spike_q;
  assign SAMPLE_SPIKES = sample_q;

endmodule
`default_nettype wire

// File: tb/tb_aer_out_receiver.sv
`default_nettype none
// ============================================================================
// tb_aer_out_receiver: directed table-driven bench for aer_out_receiver.
// Rev 1.0
// ============================================================================
module tb_aer_out_receiver;

  localparam logic [1:0] OP_HS  = 2'd0;
  localparam logic [1:0] OP_POP = 2'd1;
  localparam logic [1:0] OP_SD  = 2'd2;

  typedef struct {
    logic [1:0] op;
    logic [9:0] addr;
    int         exp_cnt;
    logic       exp_valid;
    logic [9:0] exp_head;
    int         exp_spike;
    int         exp_ss;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  aer_addr;
  logic        aer_req;
  logic        sample_done;
  logic        evt_ready;
  logic        ack, ack2;
  logic        evt_valid, evt_valid2;
  logic [9:0]  evt_addr, evt_addr2;
  logic [4:0]  fifo_count, fifo_count2;
  logic [15:0] spike_count, sample_spikes;
  logic [3:0]  spike_count2, sample_spikes2;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;
  int mon_idx  = 0;
  int cc_over  = 0;
  vec_t tbl [12];

  always #5 clk = ~clk;

  aer_out_receiver #(.ADDR_W(10), .FIFO_DEPTH(16), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .AEROUT_ADDR(aer_addr), .AEROUT_REQ(aer_req),
    .AEROUT_ACK(ack), .SAMPLE_DONE(sample_done), .EVT_VALID(evt_valid),
    .EVT_ADDR(evt_addr), .EVT_READY(evt_ready), .FIFO_COUNT(fifo_count),
    .SPIKE_COUNT(spike_count), .SAMPLE_SPIKES(sample_spikes)
  );

  aer_out_receiver #(.ADDR_W(10), .FIFO_DEPTH(16), .CNT_W(4)) dut_sat (
    .CLK(clk), .RST(rst), .AEROUT_ADDR(aer_addr), .AEROUT_REQ(aer_req),
    .AEROUT_ACK(ack2), .SAMPLE_DONE(sample_done), .EVT_VALID(evt_valid2),
    .EVT_ADDR(evt_addr2), .EVT_READY(evt_ready), .FIFO_COUNT(fifo_count2),
    .SPIKE_COUNT(spike_count2), .SAMPLE_SPIKES(sample_spikes2)
  );

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  task automatic wait_ack(input logic lvl, input int max, output int edges);
    edges = 0;
    for (int k = 0; k < max; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (ack == lvl) return;
    end
    edges = max + 1;
  endtask

  task automatic hs(input logic [9:0] a);
    int e;
    @(negedge clk);
    aer_addr = a;
    aer_req  = 1'b1;
    wait_ack(1'b1, 20, e);
    if (e > 20) chk("hs_ack_rise_timeout", e, 3);
    @(negedge clk);
    aer_req = 1'b0;
    wait_ack(1'b0, 20, e);
    if (e > 20) chk("hs_ack_fall_timeout", e, 3);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic pulse_sd();
    @(negedge clk);
    sample_done = 1'b1;
    @(negedge clk);
    sample_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (evt_valid && evt_ready) begin
        chk("cc_order", int'(evt_addr), mon_idx);
        mon_idx++;
      end
      if (fifo_count > 5'd1) cc_over = 1;
    end
  end

  initial begin
    int e;
    bit stalled;

    tbl[0]  = '{OP_HS,  10'h3FF, 2, 1'b1, 10'h0A5, 2, 0};
    tbl[1]  = '{OP_HS,  10'h001, 3, 1'b1, 10'h0A5, 3, 0};
    tbl[2]  = '{OP_POP, 10'h000, 2, 1'b1, 10'h3FF, 3, 0};
    tbl[3]  = '{OP_SD,  10'h000, 2, 1'b1, 10'h3FF, 0, 3};
    tbl[4]  = '{OP_POP, 10'h000, 1, 1'b1, 10'h001, 0, 3};
    tbl[5]  = '{OP_HS,  10'h155, 2, 1'b1, 10'h001, 1, 3};
    tbl[6]  = '{OP_POP, 10'h000, 1, 1'b1, 10'h155, 1, 3};
    tbl[7]  = '{OP_POP, 10'h000, 0, 1'b0, 10'h000, 1, 3};
    tbl[8]  = '{OP_POP, 10'h000, 0, 1'b0, 10'h000, 1, 3};
    tbl[9]  = '{OP_HS,  10'h2AA, 1, 1'b1, 10'h2AA, 2, 3};
    tbl[10] = '{OP_POP, 10'h000, 0, 1'b0, 10'h000, 2, 3};
    tbl[11] = '{OP_SD,  10'h000, 0, 1'b0, 10'h000, 0, 2};

    rst = 1'b0; aer_addr = '0; aer_req = 1'b0; sample_done = 1'b0; evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", int'(ack), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_addr", int'(evt_addr), 0);
    chk("rst_spike", int'(spike_count), 0);
    chk("rst_sample", int'(sample_spikes), 0);
    rst = 1'b1;

    // Single event with exact handshake latency
    @(negedge clk);
    aer_addr = 10'h0A5;
    aer_req  = 1'b1;
    wait_ack(1'b1, 10, e);
    chk("single_rise_edges", e, 3);
    chk("single_valid", int'(evt_valid), 1);
    chk("single_addr", int'(evt_addr), 'h0A5);
    chk("single_count", int'(fifo_count), 1);
    chk("single_spike", int'(spike_count), 1);
    @(negedge clk);
    aer_req = 1'b0;
    wait_ack(1'b0, 10, e);
    chk("single_fall_edges", e, 3);

    for (int i = 0; i < 12; i++) begin
      case (tbl[i].op)
        OP_HS:   hs(tbl[i].addr);
        OP_POP:  pulse_ready();
        default: pulse_sd();
      endcase
      @(negedge clk);
      chk($sformatf("tbl%0d_count", i), int'(fifo_count), tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_valid", i), int'(evt_valid), int'(tbl[i].exp_valid));
      if (tbl[i].exp_valid)
        chk($sformatf("tbl%0d_head", i), int'(evt_addr), int'(tbl[i].exp_head));
      chk($sformatf("tbl%0d_spike", i), int'(spike_count), tbl[i].exp_spike);
      chk($sformatf("tbl%0d_sample", i), int'(sample_spikes), tbl[i].exp_ss);
    end

    // Fill to 16, 17th stalls until a pop frees a slot
    for (int i = 0; i < 16; i++) hs(10'(10'h100 + i));
    @(negedge clk);
    chk("fill_count", int'(fifo_count), 16);
    aer_addr = 10'h110;
    aer_req  = 1'b1;
    stalled  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (ack) stalled = 1'b0;
    end
    chk("fill_stall_ack", int'(stalled), 1);
    chk("fill_stall_count", int'(fifo_count), 16);
    @(negedge clk);
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("fill_pop_edge_ack", int'(ack), 0);
    chk("fill_pop_edge_count", int'(fifo_count), 15);
    @(negedge clk);
    evt_ready = 1'b0;
    wait_ack(1'b1, 5, e);
    chk("fill_unstall_ack", int'(ack), 1);
    chk("fill_unstall_count", int'(fifo_count), 16);
    @(negedge clk);
    aer_req = 1'b0;
    wait_ack(1'b0, 10, e);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("fill_drain%0d", i), int'(evt_addr), 'h100 + i);
      pulse_ready();
    end
    @(negedge clk);
    chk("fill_empty", int'(evt_valid), 0);

    // Concurrent push/pop with consumer always ready
    @(negedge clk);
    evt_ready = 1'b1;
    mon_en    = 1'b1;
    for (int i = 0; i < 100; i++) hs(10'(i));
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    chk("cc_total", mon_idx, 100);
    chk("cc_max_count", cc_over, 0);

    // Sample boundary coincident with a push
    pulse_sd();
    for (int i = 0; i < 5; i++) hs(10'(10'h040 + i));
    @(negedge clk);
    aer_addr = 10'h03C;
    aer_req  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sample_done = 1'b1;
    @(posedge clk);
    #1;
    chk("sd_push_ack", int'(ack), 1);
    chk("sd_sample_spikes", int'(sample_spikes), 6);
    chk("sd_spike_count", int'(spike_count), 1);
    @(negedge clk);
    sample_done = 1'b0;
    aer_req     = 1'b0;
    wait_ack(1'b0, 10, e);

    // Saturation on the narrow-counter instance
    pulse_sd();
    for (int i = 0; i < 20; i++) hs(10'(i));
    @(negedge clk);
    chk("sat_spike_cnt4", int'(spike_count2), 15);
    chk("sat_spike_cnt16", int'(spike_count), 20);

    // Reset in the middle of a handshake
    @(negedge clk);
    evt_ready = 1'b0;
    aer_addr  = 10'h2C3;
    aer_req   = 1'b1;
    wait_ack(1'b1, 10, e);
    chk("rmid_pre_count", int'(fifo_count), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rmid_ack", int'(ack), 0);
    chk("rmid_count", int'(fifo_count), 0);
    chk("rmid_valid", int'(evt_valid), 0);
    chk("rmid_spike", int'(spike_count), 0);
    @(negedge clk);
    rst = 1'b1;
    wait_ack(1'b1, 10, e);
    chk("rmid_reack_edges", e, 3);
    chk("rmid_repush_count", int'(fifo_count), 1);
    chk("rmid_repush_head", int'(evt_addr), 'h2C3);
    @(negedge clk);
    aer_req = 1'b0;
    wait_ack(1'b0, 10, e);
    chk("rmid_fall_edges", e, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
